state_dump_reader: RTL and testbench
====================================

Name: state_dump_reader

Overview:
- End-of-run reader that walks the register file and then the data memory, emitting one word per handshake for the testbench or console.
- It is the read-side counterpart of the instruction-memory program loader.
- While active, the processor top muxes `dump_active`, `rf_addr` and `mem_addr`/`mem_read` into the register file and data memory in place of datapath addresses.
- Sits beside the processor core and is driven by the top-level harness after execution stops.

Parameters:
- REG_COUNT, 32, number of register-file entries dumped (indices 0..REG_COUNT-1); 1..32.
- MEM_WORDS, 64, number of 32-bit data-memory words dumped; 0 disables the memory phase.
- MEM_BASE, 0, byte address of the first dumped memory word; must be a multiple of 4.
- MEM_LAT, 1, cycles from `mem_addr`/`mem_read` asserted to `mem_data` valid; 1..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE or DONE.
- dump_active  out  1  high from the cycle after an accepted start until the cycle the last word is accepted; top-level mux select.
- done  out  1  level; high after a completed dump until the next accepted start or reset.
- rf_addr  out  5  register-file read address (read port 1).
- rf_data  in  32  register-file read data; combinational from rf_addr.
- mem_addr  out  32  data-memory byte address.
- mem_read  out  1  data-memory read enable.
- mem_data  in  32  data-memory read data.
- dump_valid  out  1  output word valid.
- dump_ready  in  1  consumer accepts the word when dump_valid and dump_ready are both high at clk.
- dump_is_mem  out  1  0 = register word, 1 = memory word.
- dump_index  out  16  register number, or memory word index (0-based from MEM_BASE).
- dump_data  out  32  dumped value.

Behaviour:
- States: IDLE, REG_RD, REG_OUT, MEM_REQ, MEM_WAIT, MEM_OUT, DONE.
- Reset (any state, any cycle):
  - State goes to IDLE.
  - All outputs 0: dump_active, done, dump_valid, mem_read, rf_addr, mem_addr, dump_is_mem, dump_index, dump_data.
  - Internal index counter cleared.
  - A reset mid-dump abandons the dump; no partial done.
- IDLE/DONE + start → REG_RD.
  - Index := 0; done := 0; dump_active := 1.
  - start in any other state is ignored.
- REG_RD:
  - rf_addr = index.
  - At the next edge, capture rf_data into dump_data; dump_is_mem := 0; dump_index := index; dump_valid := 1; go to REG_OUT.
- REG_OUT:
  - Hold dump_valid and all dump_* stable until accepted.
  - On accept: dump_valid := 0.
  - If index = REG_COUNT-1: go to MEM_REQ with index := 0, or to DONE if MEM_WORDS = 0.
  - Otherwise index := index+1 and go to REG_RD.
- Register phase timing: 2 cycles per word minimum (RD + OUT with dump_ready held high).
- MEM_REQ:
  - mem_addr = MEM_BASE + 4*index (32-bit, wraps modulo 2^32).
  - mem_read := 1; go to MEM_WAIT.
- MEM_WAIT:
  - Hold mem_addr and mem_read for MEM_LAT cycles (latency counter).
  - Then capture mem_data into dump_data; dump_is_mem := 1; dump_index := index; dump_valid := 1; mem_read := 0; go to MEM_OUT.
- MEM_OUT:
  - Same acceptance rule as REG_OUT.
  - On accept with index = MEM_WORDS-1, go to DONE; otherwise index+1 → MEM_REQ.
- DONE:
  - dump_active := 0 and done := 1 in the same edge that accepts the last word.
  - dump_valid = 0.
- mem_read is never asserted outside MEM_REQ/MEM_WAIT; rf_addr and mem_addr hold their last values when not in use.
- Backpressure: dump_ready low for any number of cycles stalls the walk with no data change and no extra memory reads.
- dump_ready high while dump_valid is low has no effect.
- Index counter width: enough for max(REG_COUNT, MEM_WORDS); dump_index is zero-extended to 16 bits.
- mem_addr never writes memory; the block has no write path to the register file or memory.

Test Plan:
1. Reset then start, dump_ready tied 1, REG_COUNT=32, MEM_WORDS=4, regfile reg i = i*3, mem word at byte 4k = 0xA000_0000+k → 36 transfers in order: regs 0..31 (dump_is_mem=0, data 0..93), then mem idx 0..3 (mem_addr 0,4,8,12, data 0xA0000000..0xA0000003); done rises on the edge accepting the last word.
2. dump_ready low for 5 cycles while reg 7 (data 21) is valid → dump_valid, dump_index=7 and dump_data=21 stable for all 5 cycles; exactly one transfer when ready rises; no skipped or duplicated index.
3. MEM_LAT=3, MEM_BASE=0x100 → mem_addr 0x100, 0x104, …; mem_read high exactly 4 cycles per word (REQ + 3 WAIT); captured data is the word at the addressed location.
4. MEM_WORDS=0 → after reg 31 is accepted, DONE is entered directly; mem_read never asserted.
5. Reset asserted while in MEM_WAIT of word 2 → next cycle all outputs 0, state IDLE, done=0; a fresh start restarts at reg 0.
6. start pulsed during REG_OUT of reg 10 → ignored, sequence continues at reg 11; start in DONE → done drops, a new dump begins at reg 0.

Source files
------------

// File: rtl/state_dump_reader.sv
// End-of-run dump engine: walks the register file, then a window of data memory,
// presenting one word per valid/ready handshake. The top muxes rf_addr/mem_addr in while dump_active.
module state_dump_reader #(
    parameter int          REG_COUNT = 32,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        dump_active,
    output logic        done,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_is_mem,
    output logic [15:0] dump_index,
    output logic [31:0] dump_data
);

    localparam int MAX_N = (REG_COUNT > MEM_WORDS) ? REG_COUNT : MEM_WORDS;
    localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);
    localparam logic [2:0]       LAT_LAST = 3'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG_RD,
        S_REG_OUT,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_MEM_OUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2:0]         lat_q, lat_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic               mem_read_q, mem_read_d;
    logic [4:0]         rf_addr_q, rf_addr_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               is_mem_q, is_mem_d;
    logic [15:0]        dindex_q, dindex_d;
    logic [31:0]        ddata_q, ddata_d;
    logic [IDX_W-1:0]   idx_inc;

    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            lat_q      <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            mem_read_q <= 1'b0;
            rf_addr_q  <= '0;
            mem_addr_q <= '0;
            is_mem_q   <= 1'b0;
            dindex_q   <= '0;
            ddata_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            active_q   <= active_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            mem_read_q <= mem_read_d;
            rf_addr_q  <= rf_addr_d;
            mem_addr_q <= mem_addr_d;
            is_mem_q   <= is_mem_d;
            dindex_q   <= dindex_d;
            ddata_q    <= ddata_d;
        end
    end

    // Addresses are registered on entry to REG_RD / MEM_REQ so they are stable for the whole access.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        active_d   = active_q;
        done_d     = done_q;
        valid_d    = valid_q;
        mem_read_d = mem_read_q;
        rf_addr_d  = rf_addr_q;
        mem_addr_d = mem_addr_q;
        is_mem_d   = is_mem_q;
        dindex_d   = dindex_q;
        ddata_d    = ddata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_REG_RD;
                    idx_d     = '0;
                    rf_addr_d = '0;
                    done_d    = 1'b0;
                    active_d  = 1'b1;
                end
            end
            S_REG_RD: begin
                ddata_d  = rf_data;
                is_mem_d = 1'b0;
                dindex_d = 16'(idx_q);
                valid_d  = 1'b1;
                state_d  = S_REG_OUT;
            end
            S_REG_OUT: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == REG_LAST) begin
                        if (MEM_WORDS == 0) begin
                            state_d  = S_DONE;
                            active_d = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            idx_d      = '0;
                            mem_addr_d = MEM_BASE;
                            mem_read_d = 1'b1;
                            state_d    = S_MEM_REQ;
                        end
                    end else begin
                        idx_d     = idx_inc;
                        rf_addr_d = 5'(idx_inc);
                        state_d   = S_REG_RD;
                    end
                end
            end
            S_MEM_REQ: begin
                lat_d   = 3'd1;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    ddata_d    = mem_data;
                    is_mem_d   = 1'b1;
                    dindex_d   = 16'(idx_q);
                    valid_d    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = S_MEM_OUT;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_MEM_OUT: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == MEM_LAST) begin
                        state_d  = S_DONE;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d      = idx_inc;
                        mem_addr_d = MEM_BASE + (32'(idx_inc) << 2);
                        mem_read_d = 1'b1;
                        state_d    = S_MEM_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dump_active = active_q;
    assign done        = done_q;
    assign rf_addr     = rf_addr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_read    = mem_read_q;
    assign dump_valid  = valid_q;
    assign dump_is_mem = is_mem_q;
    assign dump_index  = dindex_q;
    assign dump_data   = ddata_q;

endmodule

// File: tb/tb_state_dump_reader.sv
// Three dump readers (mem window 4 words/lat 1, no mem window, base 0x100/lat 3) share
// start/reset/ready; each has its own memory model and scoreboard.
module tb_state_dump_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic dump_ready = 1'b1;

    logic        dv [3];
    logic        da [3];
    logic        dn [3];
    logic        mr [3];
    logic        dim [3];
    logic [4:0]  ra [3];
    logic [31:0] ma [3];
    logic [31:0] md [3];
    logic [31:0] rd [3];
    logic [31:0] dd [3];
    logic [15:0] di [3];

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        is_mem;
        logic [15:0] idx;
        logic [31:0] data;
    } exp_t;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int          MW   = (gi == 0) ? 4 : (gi == 1) ? 0 : 3;
        localparam int          LAT  = (gi == 2) ? 3 : 1;
        localparam logic [31:0] BASE = (gi == 2) ? 32'h100 : 32'h0;

        state_dump_reader #(
            .REG_COUNT(32), .MEM_WORDS(MW), .MEM_BASE(BASE), .MEM_LAT(LAT)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start),
            .dump_active(da[gi]), .done(dn[gi]),
            .rf_addr(ra[gi]), .rf_data(rd[gi]),
            .mem_addr(ma[gi]), .mem_read(mr[gi]), .mem_data(md[gi]),
            .dump_valid(dv[gi]), .dump_ready(dump_ready),
            .dump_is_mem(dim[gi]), .dump_index(di[gi]), .dump_data(dd[gi])
        );

        // Register i holds i*3; memory word at byte 4k holds 0xA000_0000+k, read latency LAT.
        assign rd[gi] = {27'd0, ra[gi]} * 32'd3;
        logic [31:0] pipe [4];
        always @(posedge clk) begin
            if (mr[gi]) pipe[0] <= 32'hA000_0000 + (ma[gi] >> 2);
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign md[gi] = pipe[LAT-1];

        exp_t        q [$];
        bit          busy = 0;
        bit          pend_last = 0;
        bit          prev_stall = 0;
        int          rd_cnt = 0;
        logic        p_mem;
        logic [15:0] p_idx;
        logic [31:0] p_data;

        always @(negedge clk) begin
            if (reset) begin
                q.delete();
                busy = 0;
                pend_last = 0;
                prev_stall = 0;
                rd_cnt = 0;
            end else begin
                if (pend_last) begin
                    chk($sformatf("u%0d done_after_last", gi), 64'(dn[gi]), 64'd1);
                    chk($sformatf("u%0d active_after_last", gi), 64'(da[gi]), 64'd0);
                    chk($sformatf("u%0d valid_after_last", gi), 64'(dv[gi]), 64'd0);
                    chk($sformatf("u%0d reads_after_last", gi), 64'(rd_cnt), 64'd0);
                    pend_last = 0;
                end
                if (prev_stall) begin
                    chk($sformatf("u%0d stall_valid", gi), 64'(dv[gi]), 64'd1);
                    chk($sformatf("u%0d stall_word", gi), {15'd0, dim[gi], di[gi], dd[gi]},
                        {15'd0, p_mem, p_idx, p_data});
                end
                if (mr[gi]) rd_cnt++;
                if (start && !busy) begin
                    busy = 1;
                    for (int r = 0; r < 32; r++) q.push_back({1'b0, 16'(r), 32'(r * 3)});
                    for (int m = 0; m < MW; m++)
                        q.push_back({1'b1, 16'(m), 32'hA000_0000 + (BASE >> 2) + 32'(m)});
                end
                if (dv[gi] && dump_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("u%0d unexpected_word", gi), {16'd0, di[gi], dd[gi]}, 64'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk($sformatf("u%0d is_mem", gi), 64'(dim[gi]), 64'(e.is_mem));
                        chk($sformatf("u%0d index", gi), 64'(di[gi]), 64'(e.idx));
                        chk($sformatf("u%0d data", gi), 64'(dd[gi]), 64'(e.data));
                        chk($sformatf("u%0d read_cycles", gi), 64'(rd_cnt),
                            e.is_mem ? 64'(LAT + 1) : 64'd0);
                        if (e.is_mem)
                            chk($sformatf("u%0d mem_addr", gi), 64'(ma[gi]),
                                64'(BASE + 32'(e.idx) * 32'd4));
                        rd_cnt = 0;
                        if (q.size() == 0) begin
                            pend_last = 1;
                            busy = 0;
                        end
                    end
                end
                prev_stall = dv[gi] && !dump_ready;
                p_mem  = dim[gi];
                p_idx  = di[gi];
                p_data = dd[gi];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s u%0d flags", tag, i),
                {59'd0, da[i], dn[i], dv[i], mr[i], dim[i]}, 64'd0);
            chk($sformatf("%s u%0d addrs", tag, i), {27'd0, ra[i], ma[i]}, 64'd0);
            chk($sformatf("%s u%0d word", tag, i), {16'd0, di[i], dd[i]}, 64'd0);
        end
    endtask

    task automatic wait_all_done(input string tag);
        int n = 0;
        while (!(dn[0] && dn[1] && dn[2]) && n < 2000) begin
            step();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s u%0d done", tag, i), 64'(dn[i]), 64'd1);
            chk($sformatf("%s u%0d active", tag, i), 64'(da[i]), 64'd0);
        end
    endtask

    initial begin
        int n;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;
        step();

        // First dump: stall on reg 7, ignored start on reg 10.
        pulse_start();
        n = 0;
        while (!(dv[0] && di[0] == 16'd7) && n < 500) begin step(); n++; end
        chk("reach_reg7", 64'(n < 500), 64'd1);
        dump_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_reg7_word", {15'd0, dv[0], di[0], dd[0]}, {15'd1, 16'd7, 32'd21});
        end
        dump_ready = 1'b1;
        n = 0;
        while (!(dv[0] && di[0] == 16'd10) && n < 500) begin step(); n++; end
        chk("reach_reg10", 64'(n < 500), 64'd1);
        pulse_start();
        wait_all_done("dump1");

        // Start from DONE begins a new dump immediately.
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("restart u%0d done", i), 64'(dn[i]), 64'd0);
            chk($sformatf("restart u%0d active", i), 64'(da[i]), 64'd1);
        end

        // Abandon the dump while unit 0 waits on memory word 2.
        n = 0;
        while (!(mr[0] && ma[0] == 32'd8) && n < 500) begin step(); n++; end
        chk("reach_mem2", 64'(n < 500), 64'd1);
        step();
        reset = 1'b1;
        step();
        check_zero("midreset");
        reset = 1'b0;
        step();
        pulse_start();
        wait_all_done("dump3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
